// File: rtl/compact_queue_if.sv
// Bundle of enqueue/dequeue handshake signals for compact_queue.
// master drives requests, slave is the queue itself.
interface compact_queue_if #(
    parameter int DATA  = 32,
    parameter int IN    = 4,
    parameter int OUT   = 4,
    parameter int DEPTH = 16
);
    localparam int CNT = $clog2(DEPTH + 1);
    localparam int DN  = $clog2(OUT + 1);

    logic                     flush;
    logic [IN-1:0]            enq_sel;
    logic [IN-1:0][DATA-1:0]  enq_data;
    logic                     enq_ready;
    logic [OUT-1:0]           deq_valid;
    logic [OUT-1:0][DATA-1:0] deq_data;
    logic [DN-1:0]            deq_num;
    logic [CNT-1:0]           count;
    logic                     full;
    logic                     empty;

    modport master (
        output flush, enq_sel, enq_data, deq_num,
        input  enq_ready, deq_valid, deq_data, count, full, empty
    );

    modport slave (
        input  flush, enq_sel, enq_data, deq_num,
        output enq_ready, deq_valid, deq_data, count, full, empty
    );
endinterface

// File: rtl/compact_queue.sv
// Multi-lane circular queue: sparse enqueue lanes are compacted into
// consecutive slots, up to OUT oldest entries are presented for dequeue.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

// Per-lane placement: a selected lane lands at tail + (number of selected
// lanes below it), which is what keeps accepted entries contiguous.
module compact_queue_lane #(
    parameter int PTR = 4,
    parameter int CNT = 5
) (
    input  logic           sel,
    input  logic           accept,
    input  logic [PTR-1:0] tail,
    input  logic [CNT-1:0] rank,
    output logic           we,
    output logic [PTR-1:0] dest
);
    assign we   = sel & accept;
    assign dest = tail + PTR'(rank);
endmodule

module compact_queue #(
    parameter int   DATA  = 32,
    parameter int   IN    = 4,
    parameter int   OUT   = 4,
    parameter int   DEPTH = 16,
    parameter logic ACT   = `HIGH
) (
    input  logic          clk,
    input  logic          reset_,
    compact_queue_if.slave q
);
    localparam int PTR = $clog2(DEPTH);
    localparam int CNT = $clog2(DEPTH + 1);
    localparam int DN  = $clog2(OUT + 1);

    logic [PTR-1:0]  head;
    logic [PTR-1:0]  tail;
    logic [CNT-1:0]  count_r;
    logic [DATA-1:0] store [DEPTH];

    logic [IN-1:0]           sel_act;
    logic                    accept;
    logic [IN:0][CNT-1:0]    rank;
    logic [IN-1:0]           we;
    logic [IN-1:0][PTR-1:0]  dest;
    logic [CNT-1:0]          n_enq;
    logic [CNT-1:0]          n_deq;
    logic [OUT-1:0]          valid;

    assign sel_act = (ACT == 1'b1) ? q.enq_sel : ~q.enq_sel;

    // Readiness looks only at the registered count so enq_ready never
    // depends on deq_num in the same cycle.
    assign q.enq_ready = (CNT'(DEPTH) - count_r) >= CNT'(IN);
    assign accept      = q.enq_ready & ~q.flush;

    // rank[i] = selected lanes below lane i; rank[IN] is the total.
    assign rank[0] = '0;
    for (genvar i = 0; i < IN; i++) begin : g_rank
        assign rank[i+1] = rank[i] + CNT'(sel_act[i]);
    end

    for (genvar i = 0; i < IN; i++) begin : g_lane
        compact_queue_lane #(
            .PTR (PTR),
            .CNT (CNT)
        ) u_lane (
            .sel    (sel_act[i]),
            .accept (accept),
            .tail   (tail),
            .rank   (rank[i]),
            .we     (we[i]),
            .dest   (dest[i])
        );
    end

    assign n_enq = accept ? rank[IN] : '0;

    always_comb begin
        n_deq = CNT'(q.deq_num);
        if (n_deq > count_r)
            n_deq = count_r;
        if (n_deq > CNT'(OUT))
            n_deq = CNT'(OUT);
        if (q.flush)
            n_deq = '0;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
        end else begin
            head    <= head + PTR'(n_deq);
            tail    <= tail + PTR'(n_enq);
            count_r <= count_r + n_enq - n_deq;
        end
    end

    // Storage carries no reset; destinations of accepted lanes are distinct.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN; i++) begin
            if (we[i])
                store[dest[i]] <= q.enq_data[i];
        end
    end

    for (genvar k = 0; k < OUT; k++) begin : g_deq
        assign valid[k]      = CNT'(k) < count_r;
        assign q.deq_data[k] = store[head + PTR'(k)];
    end

    assign q.deq_valid = (ACT == 1'b1) ? valid : ~valid;
    assign q.count     = count_r;
    assign q.full      = count_r == CNT'(DEPTH);
    assign q.empty     = count_r == '0;
endmodule

// File: doc/compact_queue.md
COMPACT_QUEUE -- requirements
Module: compact_queue

Interface
REQ-001 The block SHALL have parameter DATA, default 32, meaning the width of one data entry in bits.
REQ-002 The block SHALL have parameter IN, default 4, meaning the number of enqueue lanes.
REQ-003 The block SHALL have parameter OUT, default 4, meaning the number of dequeue lanes.
REQ-004 The block SHALL have parameter DEPTH, default 16, meaning the number of storage entries; it SHALL be a power of 2 and at least IN+OUT.
REQ-005 The block SHALL have parameter ACT, default `HIGH, meaning the active level of enq_sel and deq_valid.
REQ-006 The constants SHALL be PTR = $clog2(DEPTH), CNT = $clog2(DEPTH+1) and DN = $clog2(OUT+1).
REQ-007 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port reset_ SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-009 Port flush SHALL be an input, 1 bit, active-high: discard all contents.
REQ-010 Port enq_sel SHALL be an input, IN bits, active level ACT: per-lane enqueue request; the mask may be sparse.
REQ-011 Port enq_data SHALL be an input, [IN][DATA]: per-lane enqueue data.
REQ-012 Port enq_ready SHALL be an output, 1 bit, active-high: the queue accepts enq_sel this cycle.
REQ-013 Port deq_valid SHALL be an output, OUT bits, active level ACT: per-lane flag that an entry is presented.
REQ-014 Port deq_data SHALL be an output, [OUT][DATA]: the oldest entries, lane 0 being the oldest.
REQ-015 Port deq_num SHALL be an input, DN bits: the number of presented entries consumed this cycle.
REQ-016 Port count SHALL be an output, CNT bits: the current occupancy.
REQ-017 Port full SHALL be an output, 1 bit, active-high, meaning count==DEPTH.
REQ-018 Port empty SHALL be an output, 1 bit, active-high, meaning count==0.

Function
REQ-019 The state SHALL be: head pointer (PTR bits), tail pointer (PTR bits), count (CNT bits), and storage buf[DEPTH][DATA]; the pointers SHALL wrap modulo DEPTH.
REQ-020 enq_ready SHALL equal (DEPTH-count >= IN), computed from the registered count only; a same-cycle dequeue SHALL NOT raise it.
REQ-021 n_enq SHALL be the number of enq_sel bits at level ACT when enq_ready=1 and flush=0, and 0 otherwise.
REQ-022 Accepted lanes SHALL be compacted in ascending lane order: the j-th selected lane (j=0..n_enq-1) is written to buf[(tail+j) mod DEPTH].
REQ-023 Unselected lanes SHALL write nothing.
REQ-024 Compaction SHALL use a gather instance with OFFSET enabled, or equivalent logic.
REQ-025 Enqueue while enq_ready=0 SHALL be dropped with no state change; no error is flagged.
REQ-026 deq_valid[k] SHALL be at level ACT iff k < count, and deq_data[k] SHALL equal buf[(head+k) mod DEPTH]; both are combinational from registered state.
REQ-027 deq_data of an invalid lane SHALL be don't-care.
REQ-028 n_deq SHALL be min(deq_num, count, OUT), and 0 when flush=1; an over-request SHALL be clamped, not an error.
REQ-029 Next state SHALL be: head += n_deq; tail += n_enq; count = count + n_enq - n_deq. Simultaneous enqueue and dequeue SHALL both take effect.
REQ-030 Latency SHALL be: data enqueued at edge t is visible on deq_data after edge t, i.e. in cycle t+1; no bypass from enq_data to deq_data.
REQ-031 flush=1 SHALL set head=tail=count=0 at the next edge; enqueue and dequeue in that cycle SHALL be ignored.
REQ-032 full/empty SHALL be derived combinationally from count.

Reset
REQ-033 While reset_=0, head, tail and count SHALL be 0 asynchronously.
REQ-034 During reset, enq_ready SHALL be 1, empty SHALL be 1, full SHALL be 0, and all deq_valid SHALL be at the inactive level.
REQ-035 buf SHALL NOT be reset.
REQ-036 Reset asserted mid-operation SHALL discard all contents identically to flush, without waiting for a clock.

Verification
REQ-037 Sparse compaction: from empty, enq_sel=4'b1010 with data {D3,D2,D1,D0} -> next cycle count=2, deq_valid=4'b0011, deq_data[0]=D1, deq_data[1]=D3.
REQ-038 Wrap-around: with head=tail=14 and count=0, enqueue 4 entries -> entries land in buf 14,15,0,1; tail=2; deq_data[0..3] are returned in enqueue order.
REQ-039 Backpressure: count=13 -> enq_ready=0, a full-mask enqueue is dropped and count stays 13; with count=12 the same enqueue -> count=16, full=1.
REQ-040 Simultaneous operation and clamp: count=3, enqueue 2 entries with deq_num=4 -> n_deq=3, count=2 next cycle, deq_data[0] is the first newly enqueued entry.
REQ-041 Flush priority: count=5, flush=1 together with an enqueue of 4 and deq_num=2 -> count=0, empty=1, head=tail=0.
REQ-042 Asynchronous reset: assert reset_=0 between clock edges while count=7 -> count=0 and deq_valid inactive immediately; after reset_ is released, normal enqueue resumes.
